// File: rtl/ac_gain_probe.sv
// ac_gain_probe
// Receive-side amplitude probe for an AC gain measurement. Paired input-node
// and output-node samples are tracked over NPER periods of the input
// channel. Each period boundary is a rising zero crossing of in_s. At the
// end of the window the block reports the peak-to-peak amplitude of both
// channels and the number of samples that were included.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   start         begin a measurement (only looked at in IDLE)
//   s_valid       sample pair valid this cycle
//   in_s, out_s   signed DW-bit samples (input node, output node)
//   busy          high while arming or measuring
//   done          one-cycle pulse when a measurement ends
//   err           timeout flag, valid with done, held until next start
//   in_pp, out_pp unsigned DW+1-bit peak-to-peak amplitudes
//   n_samp        samples included in the window (saturating)
module ac_gain_probe #(
  parameter int DW      = 12,
  parameter int NPER    = 4,
  parameter int CNT_W   = 20,
  parameter int MAX_GAP = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             s_valid,
  input  logic [DW-1:0]    in_s,
  input  logic [DW-1:0]    out_s,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [DW:0]      in_pp,
  output logic [DW:0]      out_pp,
  output logic [CNT_W-1:0] n_samp
);

  localparam int GW = $clog2(MAX_GAP + 1);
  localparam logic [GW-1:0]    GAP_LAST = GW'(MAX_GAP - 1);
  localparam logic [GW-1:0]    GAP_ONE  = GW'(1);
  localparam logic [7:0]       PER_LAST = 8'(NPER - 1);
  localparam logic [7:0]       PER_ONE  = 8'd1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS, S_DONE} state_t;

  state_t r_state, w_next;

  logic signed [DW-1:0] r_prev_in;
  logic signed [DW-1:0] r_in_min, r_in_max, r_out_min, r_out_max;
  logic [GW-1:0]        r_gap;
  logic [7:0]           r_per;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_err;
  logic [DW:0]          r_in_pp, r_out_pp;
  logic [CNT_W-1:0]     r_n_samp;

  logic signed [DW-1:0] w_in, w_out;
  logic signed [DW-1:0] w_in_lo, w_in_hi, w_out_lo, w_out_hi;
  logic                 w_active, w_cross, w_gap_hit, w_last;
  logic [DW:0]          w_in_pp, w_out_pp;
  logic [CNT_W-1:0]     w_cnt_inc;

  assign w_in  = $signed(in_s);
  assign w_out = $signed(out_s);

  assign w_active = (r_state == S_ARM) || (r_state == S_MEAS);

  // Rising crossing: previous accepted sample negative, this one >= 0.
  // Sign bits are enough for that test.
  assign w_cross   = s_valid && r_prev_in[DW-1] && !w_in[DW-1];
  assign w_gap_hit = w_active && s_valid && !w_cross && (r_gap == GAP_LAST);
  assign w_last    = (r_state == S_MEAS) && w_cross && (r_per == PER_LAST);

  assign w_in_lo  = (w_in  < r_in_min)  ? w_in  : r_in_min;
  assign w_in_hi  = (w_in  > r_in_max)  ? w_in  : r_in_max;
  assign w_out_lo = (w_out < r_out_min) ? w_out : r_out_min;
  assign w_out_hi = (w_out > r_out_max) ? w_out : r_out_max;

  // One extra bit after sign extension keeps max-min exact, e.g.
  // 2047 - (-2048) = 4095 for DW=12.
  assign w_in_pp  = {r_in_max[DW-1],  r_in_max}  - {r_in_min[DW-1],  r_in_min};
  assign w_out_pp = {r_out_max[DW-1], r_out_max} - {r_out_min[DW-1], r_out_min};

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_ONE;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_ARM;
      S_ARM: begin
        if (w_cross)        w_next = S_MEAS;
        else if (w_gap_hit) w_next = S_DONE;
      end
      S_MEAS: begin
        if (w_last)         w_next = S_DONE;
        else if (w_gap_hit) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath. Results are written on the edge that enters DONE so they are
  // already stable during the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_in <= '0;
      r_in_min  <= '0;
      r_in_max  <= '0;
      r_out_min <= '0;
      r_out_max <= '0;
      r_gap     <= '0;
      r_per     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_in_pp   <= '0;
      r_out_pp  <= '0;
      r_n_samp  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_err     <= 1'b0;
            r_gap     <= '0;
            r_per     <= '0;
            r_prev_in <= '0;  // first sample after arming can't be a crossing
          end
        end
        S_ARM: begin
          if (s_valid) begin
            r_prev_in <= w_in;
            if (w_cross) begin
              // Window opens on this crossing sample, which is included.
              r_in_min  <= w_in;
              r_in_max  <= w_in;
              r_out_min <= w_out;
              r_out_max <= w_out;
              r_cnt     <= CNT_ONE;
              r_per     <= '0;
              r_gap     <= '0;
            end else if (w_gap_hit) begin
              r_err    <= 1'b1;
              r_in_pp  <= '0;
              r_out_pp <= '0;
              r_n_samp <= '0;
            end else begin
              r_gap <= r_gap + GAP_ONE;
            end
          end
        end
        S_MEAS: begin
          if (s_valid) begin
            r_prev_in <= w_in;
            if (w_cross) begin
              r_per <= r_per + PER_ONE;
              if (w_last) begin
                // Closing crossing belongs to the next period: not included.
                r_in_pp  <= w_in_pp;
                r_out_pp <= w_out_pp;
                r_n_samp <= r_cnt;
              end else begin
                r_in_min  <= w_in_lo;
                r_in_max  <= w_in_hi;
                r_out_min <= w_out_lo;
                r_out_max <= w_out_hi;
                r_cnt     <= w_cnt_inc;
                r_gap     <= '0;
              end
            end else if (w_gap_hit) begin
              r_err    <= 1'b1;
              r_in_pp  <= '0;
              r_out_pp <= '0;
              r_n_samp <= '0;
            end else begin
              r_in_min  <= w_in_lo;
              r_in_max  <= w_in_hi;
              r_out_min <= w_out_lo;
              r_out_max <= w_out_hi;
              r_cnt     <= w_cnt_inc;
              r_gap     <= r_gap + GAP_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = w_active;
  assign done   = (r_state == S_DONE);
  assign err    = r_err;
  assign in_pp  = r_in_pp;
  assign out_pp = r_out_pp;
  assign n_samp = r_n_samp;

endmodule

// File: tb/tb_ac_gain_probe.sv
// Directed bench for ac_gain_probe. Three instances share clock, reset and
// sample inputs, each with its own start:
//   a: NPER=2, MAX_GAP=16       (triangle, valid gaps, timeout, reset, start held)
//   b: NPER=1, MAX_GAP=16       (full-scale extremes)
//   c: NPER=1, MAX_GAP=64, CNT_W=3 (sample counter saturation)
module tb_ac_gain_probe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [11:0] in_s = '0, out_s = '0;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

  logic        busy_a, done_a, err_a;
  logic [12:0] in_pp_a, out_pp_a;
  logic [19:0] n_samp_a;
  logic        busy_b, done_b, err_b;
  logic [12:0] in_pp_b, out_pp_b;
  logic [19:0] n_samp_b;
  logic        busy_c, done_c, err_c;
  logic [12:0] in_pp_c, out_pp_c;
  logic [2:0]  n_samp_c;

  int n_chk  = 0;
  int n_fail = 0;

  int tri_v [8] = '{-4, -2, 0, 2, 4, 2, 0, -2};

  always #5 clk = ~clk;

  ac_gain_probe #(.DW(12), .NPER(2), .CNT_W(20), .MAX_GAP(16)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .s_valid(s_valid),
    .in_s(in_s), .out_s(out_s), .busy(busy_a), .done(done_a), .err(err_a),
    .in_pp(in_pp_a), .out_pp(out_pp_a), .n_samp(n_samp_a));

  ac_gain_probe #(.DW(12), .NPER(1), .CNT_W(20), .MAX_GAP(16)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .s_valid(s_valid),
    .in_s(in_s), .out_s(out_s), .busy(busy_b), .done(done_b), .err(err_b),
    .in_pp(in_pp_b), .out_pp(out_pp_b), .n_samp(n_samp_b));

  ac_gain_probe #(.DW(12), .NPER(1), .CNT_W(3), .MAX_GAP(64)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .s_valid(s_valid),
    .in_s(in_s), .out_s(out_s), .busy(busy_c), .done(done_c), .err(err_c),
    .in_pp(in_pp_c), .out_pp(out_pp_c), .n_samp(n_samp_c));

  // Drive one sample at the falling edge, return 1 time unit after the
  // following rising edge so outputs can be sampled.
  task automatic step(input logic v, input int i, input int o);
    @(negedge clk);
    s_valid = v;
    in_s    = 12'(i);
    out_s   = 12'(o);
    @(posedge clk);
    #1;
  endtask

  // Feed n valid triangle samples (out = 3*in); optionally an invalid cycle
  // with junk data between valid ones. Counts done_a pulses seen before the
  // final sample.
  task automatic feed_tri(input int n, input bit toggle, output int early);
    early = 0;
    for (int k = 0; k < n; k++) begin
      step(1'b1, tri_v[k % 8], 3 * tri_v[k % 8]);
      if (k < n - 1) begin
        if (done_a) early++;
        if (toggle) begin
          step(1'b0, 100, -100);
          if (done_a) early++;
        end
      end
    end
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    step(1'b0, 0, 0);
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_chk++; if (busy_a !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %0d want 0", busy_a); end
    n_chk++; if (done_a !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %0d want 0", done_a); end
    n_chk++; if (err_a !== 1'b0)     begin n_fail++; $display("FAIL reset_err got %0d want 0", err_a); end
    n_chk++; if (in_pp_a !== 13'd0)  begin n_fail++; $display("FAIL reset_in_pp got %0d want 0", in_pp_a); end
    n_chk++; if (out_pp_a !== 13'd0) begin n_fail++; $display("FAIL reset_out_pp got %0d want 0", out_pp_a); end
    n_chk++; if (n_samp_a !== 20'd0) begin n_fail++; $display("FAIL reset_n_samp got %0d want 0", n_samp_a); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_triangle();
    int early;
    pulse_start_a();
    n_chk++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL tri_busy_after_start got %0d want 1", busy_a); end
    feed_tri(19, 1'b0, early);
    n_chk++; if (early !== 0)          begin n_fail++; $display("FAIL tri_early_done got %0d want 0", early); end
    n_chk++; if (done_a !== 1'b1)      begin n_fail++; $display("FAIL tri_done got %0d want 1", done_a); end
    n_chk++; if (busy_a !== 1'b0)      begin n_fail++; $display("FAIL tri_busy_at_done got %0d want 0", busy_a); end
    n_chk++; if (err_a !== 1'b0)       begin n_fail++; $display("FAIL tri_err got %0d want 0", err_a); end
    n_chk++; if (in_pp_a !== 13'd8)    begin n_fail++; $display("FAIL tri_in_pp got %0d want 8", in_pp_a); end
    n_chk++; if (out_pp_a !== 13'd24)  begin n_fail++; $display("FAIL tri_out_pp got %0d want 24", out_pp_a); end
    n_chk++; if (n_samp_a !== 20'd16)  begin n_fail++; $display("FAIL tri_n_samp got %0d want 16", n_samp_a); end
    step(1'b0, 0, 0);
    n_chk++; if (done_a !== 1'b0)      begin n_fail++; $display("FAIL tri_done_pulse_width got %0d want 0", done_a); end
  endtask

  task automatic test_valid_toggle();
    int early;
    pulse_start_a();
    feed_tri(19, 1'b1, early);
    n_chk++; if (early !== 0)          begin n_fail++; $display("FAIL tog_early_done got %0d want 0", early); end
    n_chk++; if (done_a !== 1'b1)      begin n_fail++; $display("FAIL tog_done got %0d want 1", done_a); end
    n_chk++; if (in_pp_a !== 13'd8)    begin n_fail++; $display("FAIL tog_in_pp got %0d want 8", in_pp_a); end
    n_chk++; if (out_pp_a !== 13'd24)  begin n_fail++; $display("FAIL tog_out_pp got %0d want 24", out_pp_a); end
    n_chk++; if (n_samp_a !== 20'd16)  begin n_fail++; $display("FAIL tog_n_samp got %0d want 16", n_samp_a); end
    step(1'b0, 0, 0);
  endtask

  task automatic test_timeout();
    int early = 0;
    pulse_start_a();
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 5, 7);
      if (k < 15 && done_a) early++;
    end
    n_chk++; if (early !== 0)          begin n_fail++; $display("FAIL to_early_done got %0d want 0", early); end
    n_chk++; if (done_a !== 1'b1)      begin n_fail++; $display("FAIL to_done got %0d want 1", done_a); end
    n_chk++; if (err_a !== 1'b1)       begin n_fail++; $display("FAIL to_err got %0d want 1", err_a); end
    n_chk++; if (in_pp_a !== 13'd0)    begin n_fail++; $display("FAIL to_in_pp got %0d want 0", in_pp_a); end
    n_chk++; if (out_pp_a !== 13'd0)   begin n_fail++; $display("FAIL to_out_pp got %0d want 0", out_pp_a); end
    n_chk++; if (n_samp_a !== 20'd0)   begin n_fail++; $display("FAIL to_n_samp got %0d want 0", n_samp_a); end
    step(1'b1, 5, 7);
    step(1'b0, 0, 0);
    n_chk++; if (err_a !== 1'b1)       begin n_fail++; $display("FAIL to_err_held got %0d want 1", err_a); end
    n_chk++; if (busy_a !== 1'b0)      begin n_fail++; $display("FAIL to_idle_busy got %0d want 0", busy_a); end
  endtask

  task automatic test_err_clear();
    int early;
    pulse_start_a();
    n_chk++; if (err_a !== 1'b0)       begin n_fail++; $display("FAIL clr_err got %0d want 0", err_a); end
    n_chk++; if (busy_a !== 1'b1)      begin n_fail++; $display("FAIL clr_busy got %0d want 1", busy_a); end
    feed_tri(19, 1'b0, early);
    n_chk++; if (done_a !== 1'b1)      begin n_fail++; $display("FAIL clr_done got %0d want 1", done_a); end
    n_chk++; if (in_pp_a !== 13'd8)    begin n_fail++; $display("FAIL clr_in_pp got %0d want 8", in_pp_a); end
    step(1'b0, 0, 0);
  endtask

  task automatic test_extremes();
    start_b = 1'b1;
    step(1'b0, 0, 0);
    start_b = 1'b0;
    step(1'b1, -2048, -2048);
    step(1'b1,  2047,  2047);
    step(1'b1, -2048, -2048);
    n_chk++; if (done_b !== 1'b0)      begin n_fail++; $display("FAIL ext_early_done got %0d want 0", done_b); end
    step(1'b1,  2047,  2047);
    n_chk++; if (done_b !== 1'b1)      begin n_fail++; $display("FAIL ext_done got %0d want 1", done_b); end
    n_chk++; if (err_b !== 1'b0)       begin n_fail++; $display("FAIL ext_err got %0d want 0", err_b); end
    n_chk++; if (in_pp_b !== 13'd4095) begin n_fail++; $display("FAIL ext_in_pp got %0d want 4095", in_pp_b); end
    n_chk++; if (out_pp_b !== 13'd4095) begin n_fail++; $display("FAIL ext_out_pp got %0d want 4095", out_pp_b); end
    n_chk++; if (n_samp_b !== 20'd2)   begin n_fail++; $display("FAIL ext_n_samp got %0d want 2", n_samp_b); end
    step(1'b0, 0, 0);
  endtask

  task automatic test_saturation();
    start_c = 1'b1;
    step(1'b0, 0, 0);
    start_c = 1'b0;
    step(1'b1, -1, -1);
    step(1'b1, 0, 0);                       // opening crossing, count 1
    for (int k = 0; k < 10; k++) step(1'b1, 3, 3);
    step(1'b1, -1, -1);                     // 12 included, saturates at 7
    step(1'b1, 0, 0);                       // closing crossing
    n_chk++; if (done_c !== 1'b1)      begin n_fail++; $display("FAIL sat_done got %0d want 1", done_c); end
    n_chk++; if (n_samp_c !== 3'd7)    begin n_fail++; $display("FAIL sat_n_samp got %0d want 7", n_samp_c); end
    n_chk++; if (in_pp_c !== 13'd4)    begin n_fail++; $display("FAIL sat_in_pp got %0d want 4", in_pp_c); end
    step(1'b0, 0, 0);
  endtask

  task automatic test_reset_mid();
    int early;
    int seen_done = 0;
    pulse_start_a();
    for (int k = 0; k < 8; k++) step(1'b1, tri_v[k], 3 * tri_v[k]);
    n_chk++; if (busy_a !== 1'b1)      begin n_fail++; $display("FAIL rm_busy_before got %0d want 1", busy_a); end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_chk++; if (busy_a !== 1'b0)      begin n_fail++; $display("FAIL rm_busy got %0d want 0", busy_a); end
    n_chk++; if (in_pp_a !== 13'd0)    begin n_fail++; $display("FAIL rm_in_pp got %0d want 0", in_pp_a); end
    n_chk++; if (out_pp_a !== 13'd0)   begin n_fail++; $display("FAIL rm_out_pp got %0d want 0", out_pp_a); end
    n_chk++; if (n_samp_a !== 20'd0)   begin n_fail++; $display("FAIL rm_n_samp got %0d want 0", n_samp_a); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done_a) seen_done++;
    end
    n_chk++; if (seen_done !== 0)      begin n_fail++; $display("FAIL rm_no_done got %0d want 0", seen_done); end
    @(negedge clk);
    rst = 1'b0;
    pulse_start_a();
    feed_tri(19, 1'b0, early);
    n_chk++; if (done_a !== 1'b1)      begin n_fail++; $display("FAIL rm_restart_done got %0d want 1", done_a); end
    n_chk++; if (in_pp_a !== 13'd8)    begin n_fail++; $display("FAIL rm_restart_in_pp got %0d want 8", in_pp_a); end
    n_chk++; if (out_pp_a !== 13'd24)  begin n_fail++; $display("FAIL rm_restart_out_pp got %0d want 24", out_pp_a); end
    n_chk++; if (n_samp_a !== 20'd16)  begin n_fail++; $display("FAIL rm_restart_n_samp got %0d want 16", n_samp_a); end
    step(1'b0, 0, 0);
  endtask

  task automatic test_start_held();
    int early;
    start_a = 1'b1;
    step(1'b0, 0, 0);
    n_chk++; if (busy_a !== 1'b1)      begin n_fail++; $display("FAIL sh_busy got %0d want 1", busy_a); end
    feed_tri(19, 1'b0, early);
    n_chk++; if (early !== 0)          begin n_fail++; $display("FAIL sh_early_done got %0d want 0", early); end
    n_chk++; if (done_a !== 1'b1)      begin n_fail++; $display("FAIL sh_done got %0d want 1", done_a); end
    n_chk++; if (in_pp_a !== 13'd8)    begin n_fail++; $display("FAIL sh_in_pp got %0d want 8", in_pp_a); end
    n_chk++; if (out_pp_a !== 13'd24)  begin n_fail++; $display("FAIL sh_out_pp got %0d want 24", out_pp_a); end
    n_chk++; if (n_samp_a !== 20'd16)  begin n_fail++; $display("FAIL sh_n_samp got %0d want 16", n_samp_a); end
    step(1'b0, 0, 0);                       // back in IDLE
    n_chk++; if (busy_a !== 1'b0)      begin n_fail++; $display("FAIL sh_idle_busy got %0d want 0", busy_a); end
    step(1'b0, 0, 0);                       // held start re-arms
    n_chk++; if (busy_a !== 1'b1)      begin n_fail++; $display("FAIL sh_rearm_busy got %0d want 1", busy_a); end
    start_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_triangle();
    test_valid_toggle();
    test_timeout();
    test_err_clear();
    test_extremes();
    test_saturation();
    test_reset_mid();
    test_start_held();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ac_gain_probe.md
Name: ac_gain_probe

Overview:
- Digital receive-side counterpart to an AC gain stimulus. A sinusoid drives the amplifier under test. This block takes paired input and output samples from the ADC path and measures peak-to-peak amplitude of each over a programmed number of stimulus periods.
- Periods are framed by rising zero crossings of the input channel.
- Results feed the gain/phase equation stage as raw amplitudes plus a sample count.

Parameters:
- DW, 12, signed sample width of both channels
- NPER, 4, number of input periods per measurement (1..255)
- CNT_W, 20, width of sample counter
- MAX_GAP, 4096, maximum accepted samples between rising crossings before timeout

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin measurement; sampled only in IDLE
- s_valid  in  1  sample pair valid this cycle
- in_s  in  DW  signed input-node sample
- out_s  in  DW  signed output-node sample
- busy  out  1  high in ARM and MEAS
- done  out  1  one-cycle pulse when a measurement ends (success or timeout)
- err  out  1  timeout flag; valid with done, held until next start
- in_pp  out  DW+1  unsigned max(in_s) - min(in_s) over the window
- out_pp  out  DW+1  unsigned max(out_s) - min(out_s) over the window
- n_samp  out  CNT_W  samples included in the window

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, err=0, in_pp=0, out_pp=0, n_samp=0; prev sample register cleared to 0; all counters cleared.
- Rising crossing: an accepted sample (s_valid=1) with prev_in<0 and in_s>=0. prev_in updates on every accepted sample in ARM/MEAS only. On entry to ARM, prev_in=0, so the first accepted sample can never be a crossing.
- IDLE: start=1 -> ARM next cycle. Clear err, gap counter and period counter; results keep their old values. start is ignored outside IDLE.
- ARM: wait for a rising crossing.
  - On the crossing sample -> MEAS. Init min/max of both channels to this sample; n_samp counter=1; period count=0; gap=0.
- MEAS: on each accepted sample:
  - If the sample is a rising crossing: period count+1. If the new count==NPER, this sample is NOT included; go to DONE. Otherwise include it and reset gap to 0.
  - If it is not a crossing: include it (update min/max of both channels, n_samp+1) and increment gap.
- Timeout: in ARM or MEAS, if gap reaches MAX_GAP accepted samples without a rising crossing -> DONE with err=1. gap counts accepted samples since entering ARM or since the last crossing. In that case in_pp, out_pp and n_samp are set to 0.
- DONE (one cycle): latch in_pp=in_max-in_min and out_pp=out_max-out_min, both computed at DW+1 bits with no overflow. Latch n_samp. done=1; busy=0. Next cycle -> IDLE.
- Latency: done is asserted the cycle after the terminating crossing sample is accepted.
- n_samp saturates at all-ones and does not wrap. s_valid=0 cycles have no effect on any counter.
- Reset during ARM or MEAS aborts the measurement: no done pulse, outputs zero.

Test Plan:
- Input triangle of period 8 (-4,-2,0,2,4,2,0,-2, repeating), out_s=3*in_s, NPER=2, s_valid always 1, start pulse -> busy high from the cycle after start. The first 0 after -2 starts MEAS. done pulses one cycle after the third crossing sample with in_pp=8, out_pp=24, n_samp=16, err=0.
- Same stimulus with s_valid toggling 1,0,1,0 -> identical results; done occurs one cycle after the corresponding accepted crossing sample.
- Constant in_s=5, MAX_GAP=16 -> done one cycle after the 16th accepted sample, err=1, in_pp=0, out_pp=0, n_samp=0.
- Extremes: in_s alternating -2048 and 2047 (DW=12), NPER=1 -> in_pp=4095 with no overflow, n_samp=2.
- Assert rst mid-MEAS -> all outputs 0 immediately without a clock edge, no done pulse. A new start then yields correct results.
- start held high through a measurement -> the second measurement begins only after returning to IDLE. start asserted during MEAS has no effect on the current measurement's results.
